// File: rtl/cache_ctrl_assoc_if.sv
// CPU-side and DRAM-side bus bundle for the set-associative cache controller.
interface cache_ctrl_assoc_if #(
  parameter int unsigned ADDR  = 32,
  parameter int unsigned DATA  = 32,
  parameter int unsigned CNT_W = 16
) ();

  // CPU (LSU) side
  logic             cpu_req;
  logic             cpu_we;
  logic [ADDR-1:0]  cpu_addr;
  logic [DATA-1:0]  cpu_wdata;
  logic             cpu_ready;
  logic             cpu_done;
  logic [DATA-1:0]  cpu_rdata;

  // DRAM side
  logic             mem_req;
  logic             mem_we;
  logic [ADDR-1:0]  mem_addr;
  logic [DATA-1:0]  mem_wdata;
  logic             mem_ready;
  logic [DATA-1:0]  mem_rdata;

  // Performance counters
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  // Controller view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    output cpu_ready, cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output hit_count, miss_count
  );

  // Environment view (LSU + DRAM)
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    input  cpu_ready, cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative, write-back, write-allocate data cache controller
// with integrated tag/valid/dirty/data arrays and saturating hit/miss counters.
module cache_ctrl_assoc #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 64,
  parameter int unsigned DATA  = 32,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_ctrl_assoc_if.slave    bus
);

  localparam int unsigned OFF   = $clog2(DATA / 8);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR - IDX_W - OFF;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_WRITEBACK = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic             req_we_q;
  logic [DATA-1:0]  req_wdata_q;

  // Victim chosen at lookup, and whether the round-robin pointer picked it
  logic [WAY_W-1:0] vict_q, vict_d;
  logic             vict_ptr_q, vict_ptr_d;

  // Storage arrays
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [DATA-1:0]  data_mem [WAYS][SETS];
  logic [SETS-1:0]  valid_q  [WAYS];
  logic [SETS-1:0]  dirty_q  [WAYS];
  logic [WAY_W-1:0] ptr_q    [SETS];

  // Registered outputs
  logic             cpu_done_q,  cpu_done_d;
  logic [DATA-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic             mem_req_q,   mem_req_d;
  logic             mem_we_q,    mem_we_d;
  logic [ADDR-1:0]  mem_addr_q,  mem_addr_d;
  logic [DATA-1:0]  mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Array update strobes
  logic             hit_inc, miss_inc;
  logic             line_we, line_fill, dirty_set, dirty_clr, ptr_adv;
  logic [WAY_W-1:0] line_way;
  logic [DATA-1:0]  line_data;

  // Lookup results
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lk_vict;
  logic             lk_vict_dirty;

  logic accept;
  assign accept = (state_q == S_IDLE) && bus.cpu_req;

  // Build a DRAM word address from tag and index with zero offset bits
  function automatic logic [ADDR-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                input logic [IDX_W-1:0] i);
    return ADDR'({t, i}) << OFF;
  endfunction

  // Tag compare across all ways and victim choice for the latched set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[w][req_idx_q] && (tag_mem[w][req_idx_q] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w][req_idx_q]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    lk_vict       = inv_found ? inv_way : ptr_q[req_idx_q];
    lk_vict_dirty = valid_q[lk_vict][req_idx_q] && dirty_q[lk_vict][req_idx_q];
  end

  // Next-state, next-output and array-update decode
  always_comb begin
    state_d     = state_q;
    vict_d      = vict_q;
    vict_ptr_d  = vict_ptr_q;
    cpu_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    line_we     = 1'b0;
    line_fill   = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    ptr_adv     = 1'b0;
    line_way    = vict_q;
    line_data   = req_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) state_d = S_LOOKUP;
      end

      S_LOOKUP: begin
        if (hit) begin
          hit_inc    = 1'b1;
          cpu_done_d = 1'b1;
          state_d    = S_IDLE;
          if (req_we_q) begin
            line_we   = 1'b1;
            line_way  = hit_way;
            dirty_set = 1'b1;
          end else begin
            cpu_rdata_d = data_mem[hit_way][req_idx_q];
          end
        end else begin
          miss_inc    = 1'b1;
          vict_d      = lk_vict;
          vict_ptr_d  = !inv_found;
          mem_req_d   = 1'b1;
          mem_wdata_d = data_mem[lk_vict][req_idx_q];
          if (lk_vict_dirty) begin
            state_d    = S_WRITEBACK;
            mem_we_d   = 1'b1;
            mem_addr_d = line_addr(tag_mem[lk_vict][req_idx_q], req_idx_q);
          end else begin
            state_d    = S_REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = line_addr(req_tag_q, req_idx_q);
          end
        end
      end

      S_WRITEBACK: begin
        // mem_req stays high; only direction and address switch to the refill
        if (bus.mem_ready) begin
          dirty_clr  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(req_tag_q, req_idx_q);
          state_d    = S_REFILL;
        end
      end

      S_REFILL: begin
        if (bus.mem_ready) begin
          line_we    = 1'b1;
          line_fill  = 1'b1;
          line_data  = req_we_q ? req_wdata_q : bus.mem_rdata;
          dirty_set  = req_we_q;
          dirty_clr  = !req_we_q;
          if (!req_we_q) cpu_rdata_d = bus.mem_rdata;
          ptr_adv    = vict_ptr_q;
          cpu_done_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, victim and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      vict_q      <= '0;
      vict_ptr_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vict_q      <= vict_d;
      vict_ptr_q  <= vict_ptr_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  // Valid/dirty bits and round-robin pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < int'(SETS); s++) ptr_q[s] <= '0;
    end else begin
      if (line_fill) valid_q[line_way][req_idx_q] <= 1'b1;
      if (dirty_set)      dirty_q[line_way][req_idx_q] <= 1'b1;
      else if (dirty_clr) dirty_q[line_way][req_idx_q] <= 1'b0;
      if (ptr_adv) begin
        ptr_q[req_idx_q] <= (ptr_q[req_idx_q] == WAY_W'(WAYS - 1)) ? '0
                          : ptr_q[req_idx_q] + WAY_W'(1);
      end
    end
  end

  // Tag and data arrays, not reset
  always_ff @(posedge clk) begin
    if (line_we)   data_mem[line_way][req_idx_q] <= line_data;
    if (line_fill) tag_mem[line_way][req_idx_q]  <= req_tag_q;
  end

  // Capture the request at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag_q   <= bus.cpu_addr[ADDR-1 -: TAG_W];
      req_idx_q   <= bus.cpu_addr[OFF +: IDX_W];
      req_we_q    <= bus.cpu_we;
      req_wdata_q <= bus.cpu_wdata;
    end
  end

  // Byte-offset bits never reach the arrays
  if (OFF > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^bus.cpu_addr[OFF-1:0];
  end

  assign bus.cpu_ready  = (state_q == S_IDLE);
  assign bus.cpu_done   = cpu_done_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: doc/cache_ctrl_assoc.md
Name: cache_ctrl_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache controller with integrated tag/valid/dirty/data arrays.
- Sits between the pipeline LSU and the DRAM model. Next generation of the direct-mapped controller.
- Adds: configurable associativity, dirty-line writeback, victim selection, a single request/done handshake on each side, and hit/miss performance counters.

Parameters:
- WAYS, 2, associativity. Power of 2, ≥1.
- SETS, 64, sets per way. Power of 2, ≥2.
- DATA, 32, line/word width in bits; one word per line. Multiple of 8.
- ADDR, 32, address width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_req  input  1  access request; sampled only when cpu_ready=1
- cpu_we  input  1  1=store, 0=load
- cpu_addr  input  ADDR  byte address
- cpu_wdata  input  DATA  store data
- cpu_ready  output  1  controller idle, can accept a request
- cpu_done  output  1  one-cycle pulse: access complete
- cpu_rdata  output  DATA  load data; valid while cpu_done=1, held afterwards
- mem_req  output  1  DRAM request
- mem_we  output  1  1=writeback, 0=refill read
- mem_addr  output  ADDR  DRAM word address (offset bits zero)
- mem_wdata  output  DATA  writeback data
- mem_ready  input  1  DRAM completes the transfer in the cycle it is sampled high with mem_req
- mem_rdata  input  DATA  refill data; valid when mem_ready=1
- hit_count  output  CNT_W  saturating hit counter
- miss_count  output  CNT_W  saturating miss counter

Behaviour:
- Address split:
  - OFF=$clog2(DATA/8) low bits ignored.
  - index=cpu_addr[OFF +: $clog2(SETS)].
  - tag=remaining upper bits.
- Reset (rst=0, asynchronous) clears:
  - state→IDLE.
  - All valid/dirty bits, victim pointers, counters, cpu_done, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata → 0.
  - Data/tag arrays are not cleared.
- cpu_ready=1 only in IDLE (combinational decode of state). All other outputs are registered.
- A request is accepted at an edge with state=IDLE and cpu_req=1; addr/we/wdata are latched at that edge. Requests at any other time are ignored, not queued.
- States:
  - IDLE → LOOKUP on accept.
  - LOOKUP: compare the latched tag against all ways of the set. Hit = valid && tag match (at most one way).
    - Hit: load → cpu_rdata←way data; store → way data←wdata, dirty←1. cpu_done←1, hit_count++, → IDLE.
    - Miss: miss_count++. Victim = lowest-numbered invalid way, else the set's round-robin pointer. Victim valid && dirty → WRITEBACK, else → REFILL.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim data, all held stable. Edge with mem_ready=1 → REFILL; dirty cleared.
  - REFILL: mem_req=1, mem_we=0, mem_addr={latched tag, index, 0}, held stable. Edge with mem_ready=1 (fill edge):
    - victim valid←1, tag←latched tag.
    - Load: data←mem_rdata, cpu_rdata←mem_rdata, dirty←0.
    - Store: data←wdata, dirty←1.
    - cpu_done←1, mem_req←0, → IDLE.
    - If the victim was selected by the pointer, the pointer advances by 1 mod WAYS; fills into invalid ways leave it unchanged.
- mem_req stays 1 across the WRITEBACK→REFILL transition; mem_we/mem_addr change at that edge.
- Latency:
  - Hit: cpu_done high in the 2nd cycle after the accept edge.
  - Clean miss: cpu_done in the cycle after the refill mem_ready edge.
- cpu_done is high exactly one cycle per accepted request. cpu_ready returns the same cycle cpu_done rises.
- mem_ready while mem_req=0 is ignored. mem_ready may stay low indefinitely; the controller waits with outputs stable.
- Counters saturate at 2^CNT_W−1; no wrap.
- WAYS=1 degenerates to direct-mapped write-back; the pointer is unused.

Test Plan:
- Reset, load 0x100 → mem_req=1, mem_we=0, mem_addr=0x100; DRAM returns 0xDEADBEEF after 3 cycles → cpu_done, cpu_rdata=0xDEADBEEF, miss_count=1. Reload 0x100 → cpu_done 2 cycles after accept, no mem_req, hit_count=1.
- Defaults: store 0x100=0x12345678 (miss, allocate way0, dirty); load 0x200 (fills way1, no writeback); load 0x300 → WRITEBACK mem_we=1, mem_addr=0x100, mem_wdata=0x12345678, then refill 0x300; later load 0x100 misses and returns DRAM data.
- Continuing the previous scenario: load 0x400 (same set) evicts clean way1 → no writeback cycle, mem_we=0 directly.
- Hold mem_ready=0 for 20 cycles during refill → mem_req/mem_addr stable, cpu_ready=0, extra cpu_req pulses produce no cpu_done.
- Assert rst=0 mid-REFILL between clock edges → mem_req=0 immediately; after release, load of a previously cached address misses; counters read 0.
- CNT_W=4: 20 hits to one line → hit_count=15 (saturated).
